// File: rtl/mdu_pkg.sv
// Shared opcode, FSM state and latency definitions for the MIPS multiply unit controller.
// The MDU_MADD_EN macro (see mdu_mult_ctrl) enables the OP_MADD/OP_MADDU encodings.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    localparam int MUL_LAT_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_mult_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the multiply unit (slave).
interface mdu_mult_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        output req_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_mult_ctrl_mult.sv
// Combinational 32x32 signed multiplier core; its result path is timed as a multicycle path.
module mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] z
);

    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;

    assign a_ext_s = {{32{a[31]}}, a};
    assign b_ext_s = {{32{b[31]}}, b};
    // The low 64 bits of the sign-extended product are the exact signed result.
    assign z = a_ext_s * b_ext_s;

endmodule

// File: rtl/mdu_mult_ctrl.sv
// Multi-cycle HI/LO controller wrapped around the signed `mult` core.
// Define MDU_MADD_EN to add MADD/MADDU accumulate support; otherwise 100/101 are reserved.
module mdu_mult_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    mdu_mult_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    mdu_state_e  state_r;
    mdu_state_e  state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [2:0]  op_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic        latch_s;
    logic [63:0] prod_s;
    logic [31:0] uhi_s;
    logic [63:0] umul_s;
    logic [63:0] res_s;
`ifdef MDU_MADD_EN
    logic [63:0] acc_s;
`endif

    // Core sees only the held operand registers, never the live request bus.
    mult u_mult (
        .a (a_r),
        .b (b_r),
        .z (prod_s)
    );

    // Signed-to-unsigned fixup: add back b when a is "negative" and vice versa.
    assign uhi_s  = prod_s[63:32] + (a_r[31] ? b_r : 32'd0) + (b_r[31] ? a_r : 32'd0);
    assign umul_s = {uhi_s, prod_s[31:0]};
`ifdef MDU_MADD_EN
    assign acc_s  = {hi_r, lo_r} + ((op_r == OP_MADDU) ? umul_s : prod_s);
`endif

    // Select the 64-bit value committed to {hi,lo} for the in-flight opcode.
    always_comb begin
        res_s = prod_s;
        case (op_r)
            OP_MULT:  res_s = prod_s;
            OP_MULTU: res_s = umul_s;
`ifdef MDU_MADD_EN
            OP_MADD:  res_s = acc_s;
            OP_MADDU: res_s = acc_s;
`endif
            default:  res_s = prod_s;
        endcase
    end

    // Next-state, counter, HI/LO write and done logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        done_nxt_s  = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    case (bus.req_op)
                        OP_MULT, OP_MULTU: begin
                            latch_s     = 1'b1;
                            cnt_nxt_s   = CNT_LOAD;
                            state_nxt_s = CALC;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            latch_s     = 1'b1;
                            cnt_nxt_s   = CNT_LOAD;
                            state_nxt_s = CALC;
                        end
`endif
                        OP_MTHI: hi_nxt_s = bus.req_a;
                        OP_MTLO: lo_nxt_s = bus.req_a;
                        default: latch_s  = 1'b0;
                    endcase
                end else begin
                    latch_s = 1'b0;
                end
            end
            CALC: begin
                // Flush wins over the final count: the op is abandoned without commit.
                if (bus.flush) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    hi_nxt_s    = res_s[63:32];
                    lo_nxt_s    = res_s[31:0];
                    done_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, HI/LO and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Operand registers, loaded only when a multiply is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= 32'd0;
            b_r  <= 32'd0;
            op_r <= 3'b000;
        end else if (latch_s) begin
            a_r  <= bus.req_a;
            b_r  <= bus.req_b;
            op_r <= bus.req_op;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.busy      = (state_r == CALC);
    assign bus.done      = done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

endmodule

// File: doc/mdu_mult_ctrl.md
Name: mdu_mult_ctrl

Overview:
- Multi-cycle controller for the 32x32 combinational multiplier core `mult` (a,b -> z[63:0], signed two's-complement product).
- Owns the architectural HI/LO registers of the MIPS multiply unit.
- Accepts MULT/MULTU/MTHI/MTLO requests from the execute stage, registers the operands, and holds them stable for MUL_LAT cycles (multicycle path).
- Applies the unsigned correction, commits HI/LO, and reports busy so the pipeline stalls MFHI/MFLO and new multiply-unit ops.

Parameters:
- MUL_LAT, 2, cycles operands are held before the product is sampled; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold MUL_LAT-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_op  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU, 11x reserved.
- req_a  in  32  rs value.
- req_b  in  32  rt value.
- flush  in  1  pipeline flush/exception; aborts the in-flight op.
- busy  out  1  multiply in progress; pipeline stalls MFHI/MFLO while high.
- done  out  1  one-cycle pulse on the HI/LO commit of a multiply.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: state IDLE, hi=0, lo=0, done=0, busy=0, counter=0, operand regs=0. Reset has priority over every other input, including mid-CALC; an in-flight op is lost.
- FSM IDLE:
  - req_ready=1, busy=0.
  - Accept MULT/MULTU (MADD/MADDU when enabled): latch req_a/req_b/req_op into op regs, load counter with MUL_LAT-1, go to CALC.
  - Accept MTHI/MTLO: write hi or lo at that edge, stay in IDLE, done stays 0.
  - Reserved opcodes: accepted and dropped, no state change.
- FSM CALC:
  - req_ready=0, busy=1.
  - Core inputs are driven only from op regs (never from req_*).
  - Counter decrements each cycle. At the edge where counter==0: commit {hi,lo}, done<=1 for exactly one cycle, go to IDLE.
- Latency: accept edge T → commit and done at edge T+MUL_LAT; busy high for MUL_LAT cycles.
- Back-to-back: a request is accepted in the cycle done is high (state is IDLE).
- Arithmetic:
  - P = core z (signed 64).
  - MULT: {hi,lo}=P.
  - MULTU: lo=P[31:0]; hi=P[63:32] + (a[31]?b:0) + (b[31]?a:0), mod 2^32.
- flush:
  - In CALC: go to IDLE next edge, no commit, no done, hi/lo unchanged.
  - In IDLE: a simultaneous request (including MTHI/MTLO) is dropped.
  - flush has priority over counter==0.
- Never a simultaneous commit and MTHI/MTLO, since MT* is only accepted in IDLE.

Optional Feature:
- MDU_MADD_EN defined:
  - 100 MADD: {hi,lo} <= {hi,lo} + P.
  - 101 MADDU: {hi,lo} <= {hi,lo} + unsigned product.
  - 64-bit wrap, same timing as MULT.
- Undefined: opcodes 100/101 are treated as reserved (accepted, dropped, no done). The accumulate adder is absent.

Decomposition:
- Package mdu_pkg:
  - opcode constants OP_MULT..OP_MADDU.
  - FSM state encoding IDLE/CALC.
  - default MUL_LAT.
- One sub-module: instantiate the existing `mult` core unchanged.
- Unsigned correction and the accumulate adder live in mdu_mult_ctrl.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, MUL_LAT=2 → busy 2 cycles; at T+2 hi=0xFFFFFFFF lo=0xFFFFFFFE; done exactly 1 cycle.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE lo=0x00000001. MULTU a=0xFFFFFFFF b=2 → hi=0x00000001 lo=0xFFFFFFFE.
- MTHI 0x00001234 then MTLO 0x00005678 on consecutive cycles → hi/lo updated at each accept edge; busy and done never high.
- MULT 3x5 with a second MULT 7x7 held valid during CALC → second is accepted in the done cycle; results 0/15, then 0/49.
- flush asserted in 2nd CALC cycle of MULT 9x9 (hi=0xAAAA, lo=0xBBBB beforehand) → no done, hi/lo unchanged, req_ready=1 next cycle. rst mid-CALC → hi=lo=0, busy=0.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1x1 → hi=1 lo=0. Without the macro: same request → no change, no done.
